// File: rtl/axis_frame_pkg.sv
// axis_frame_pkg: FSM state encoding and width helper shared by axis_frame_master_mc and its FIFO
package axis_frame_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, SEND = 2'd2} state_t;
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/sample_set_fifo.sv
// sample_set_fifo: sample-set FIFO with level output; a push at full is accepted when a pop happens in the same cycle
module sample_set_fifo import axis_frame_pkg::*; #(
  parameter int W     = 128,
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     drop
);
  localparam int AW = cw(DEPTH);
  localparam int LW = $clog2(DEPTH) + 1;
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          full, empty, do_push, do_pop;
  assign full    = level == LW'(DEPTH);
  assign empty   = level == '0;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && !do_push;
  assign head    = mem[rd_ptr];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) mem[wr_ptr] <= din;
      if (do_push) wr_ptr <= wr_ptr == AW'(DEPTH - 1) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr == AW'(DEPTH - 1) ? '0 : rd_ptr + 1'b1;
      level <= level + LW'(do_push) - LW'(do_pop);
    end
endmodule

// File: rtl/axis_frame_master_mc.sv
// axis_frame_master_mc: buffers multi-channel sample sets and streams fixed-length AXIS frames, one beat per channel.
// FRAME_HEADER_EN adds a header beat carrying Frame_Count ahead of each frame.
module axis_frame_master_mc import axis_frame_pkg::*; #(
  parameter int DATA_W      = 32,
  parameter int NUM_CH      = 4,
  parameter int FRAME_SETS  = 16,
  parameter int FIFO_DEPTH  = 32,
  parameter int START_LEVEL = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          Enable,
  input  logic                          Sample_Valid,
  input  logic [NUM_CH*DATA_W-1:0]      Sample_Data,
  input  logic                          Clear_Flags,
  input  logic                          T_READY,
  output logic                          T_VALID,
  output logic [DATA_W-1:0]             T_DATA,
  output logic                          T_LAST,
  output logic [cw(NUM_CH)-1:0]         T_USER,
  output logic                          Send_Frame,
  output logic [$clog2(FIFO_DEPTH):0]   Fifo_Level,
  output logic                          Overflow,
  output logic                          Underrun,
  output logic [15:0]                   Frame_Count
);
  localparam int CW = cw(NUM_CH);
  localparam int SW = cw(FRAME_SETS);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
`ifdef FRAME_HEADER_EN
  localparam state_t FIRST = HDR;
`else
  localparam state_t FIRST = SEND;
`endif
  state_t                   state, next;
  logic [CW-1:0]            ch;
  logic [SW-1:0]            set;
  logic [NUM_CH*DATA_W-1:0] head;
  logic                     empty, beat, pop, last, drop, go;
  sample_set_fifo #(.W(NUM_CH*DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (Sample_Valid),
    .din   (Sample_Data),
    .pop   (pop),
    .head  (head),
    .level (Fifo_Level),
    .drop  (drop)
  );
  assign empty = Fifo_Level == '0;
  assign go    = Enable && Fifo_Level >= LW'(START_LEVEL);
  assign last  = set == SW'(FRAME_SETS - 1) && ch == CW'(NUM_CH - 1);
  assign beat  = state == SEND && T_VALID && T_READY;
  assign pop   = beat && ch == CW'(NUM_CH - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else       state <= next;
  always_comb begin
    next = state == IDLE ? (go ? FIRST : IDLE) :
           state == HDR  ? (T_READY ? SEND : HDR) :
           state == SEND ? (beat && last ? IDLE : SEND) : IDLE;
  end
  // outputs depend only on registered state, so T_READY never gates T_VALID
  always_comb begin
    T_VALID    = state == HDR || (state == SEND && !empty);
    Send_Frame = state != IDLE;
    T_USER     = state == SEND ? ch : '0;
    T_LAST     = state == SEND && !empty && last;
    T_DATA     = state == HDR ? DATA_W'(Frame_Count) :
                 T_VALID      ? head[ch*DATA_W +: DATA_W] : '0;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ch          <= '0;
      set         <= '0;
      Frame_Count <= '0;
      Overflow    <= 1'b0;
      Underrun    <= 1'b0;
    end else begin
      if (beat) ch <= ch == CW'(NUM_CH - 1) ? '0 : ch + 1'b1;
      if (pop)  set <= last ? '0 : set + 1'b1;
      if (beat && last) Frame_Count <= Frame_Count + 16'd1;
      Overflow <= drop | (Overflow & ~Clear_Flags);
      Underrun <= (state == SEND && empty) | (Underrun & ~Clear_Flags);
    end
endmodule

// File: tb/tb_axis_frame_master_mc.sv
// tb_axis_frame_master_mc: directed bench for the default build and a START_LEVEL=1 instance for underrun
`timescale 1ns/1ps
module tb_axis_frame_master_mc;
  localparam int DW = 32, NC = 4;
`ifdef FRAME_HEADER_EN
  localparam int HD = 1;
`else
  localparam int HD = 0;
`endif
  localparam int FLEN = 16*NC + HD;
  localparam int ULEN = 8*NC + HD;
  logic clk = 0, reset = 1;
  logic Enable = 0, Sample_Valid = 0, Clear_Flags = 0, T_READY = 0;
  logic [NC*DW-1:0] Sample_Data = '0;
  logic T_VALID, T_LAST, Send_Frame, Overflow, Underrun;
  logic [DW-1:0] T_DATA;
  logic [1:0] T_USER;
  logic [5:0] Fifo_Level;
  logic [15:0] Frame_Count;
  logic u_enable = 0, u_valid = 0, u_clear = 0, u_ready = 0;
  logic [NC*DW-1:0] u_data = '0;
  logic u_tvalid, u_tlast, u_send, u_overflow, u_underrun;
  logic [DW-1:0] u_tdata;
  logic [1:0] u_tuser;
  logic [3:0] u_level;
  logic [15:0] u_fc;
  axis_frame_master_mc dut (
    .clk(clk), .reset(reset), .Enable(Enable), .Sample_Valid(Sample_Valid),
    .Sample_Data(Sample_Data), .Clear_Flags(Clear_Flags), .T_READY(T_READY),
    .T_VALID(T_VALID), .T_DATA(T_DATA), .T_LAST(T_LAST), .T_USER(T_USER),
    .Send_Frame(Send_Frame), .Fifo_Level(Fifo_Level), .Overflow(Overflow),
    .Underrun(Underrun), .Frame_Count(Frame_Count)
  );
  axis_frame_master_mc #(.FRAME_SETS(8), .FIFO_DEPTH(8), .START_LEVEL(1)) dut_u (
    .clk(clk), .reset(reset), .Enable(u_enable), .Sample_Valid(u_valid),
    .Sample_Data(u_data), .Clear_Flags(u_clear), .T_READY(u_ready),
    .T_VALID(u_tvalid), .T_DATA(u_tdata), .T_LAST(u_tlast), .T_USER(u_tuser),
    .Send_Frame(u_send), .Fifo_Level(u_level), .Overflow(u_overflow),
    .Underrun(u_underrun), .Frame_Count(u_fc)
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] val(input int k, input int c);
    return 32'hA500_0000 + 32'(k) * 32'd256 + 32'(c);
  endfunction
  logic [31:0] q[$], uq[$];
  logic [31:0] e, ue, s_data;
  logic [1:0] s_user;
  logic stall, s_last;
  int beat, total, fc, u_beat, u_total, u_fcm;
  always @(negedge clk) begin
    if (reset) begin
      beat = 0; fc = 0; stall = 0;
    end else begin
      if (stall) begin
        check("hold_valid", 32'(T_VALID), 32'd1);
        check("hold_data", T_DATA, s_data);
        check("hold_user", 32'(T_USER), 32'(s_user));
        check("hold_last", 32'(T_LAST), 32'(s_last));
      end
      if (T_VALID && T_READY) begin
        if (beat < HD) e = 32'(fc);
        else if (q.size() > 0) e = q.pop_front();
        else e = 32'hDEAD_BEEF;
        check("data", T_DATA, e);
        check("user", 32'(T_USER), beat < HD ? 32'd0 : 32'((beat - HD) % NC));
        check("last", 32'(T_LAST), 32'(beat == FLEN - 1));
        if (beat == FLEN - 1) begin beat = 0; fc++; end
        else beat++;
        total++;
      end
      stall = T_VALID && !T_READY;
      s_data = T_DATA; s_user = T_USER; s_last = T_LAST;
    end
  end
  always @(negedge clk) begin
    if (reset) begin
      u_beat = 0; u_fcm = 0;
    end else if (u_tvalid && u_ready) begin
      if (u_beat < HD) ue = 32'(u_fcm);
      else if (uq.size() > 0) ue = uq.pop_front();
      else ue = 32'hDEAD_BEEF;
      check("u_data", u_tdata, ue);
      check("u_user", 32'(u_tuser), u_beat < HD ? 32'd0 : 32'((u_beat - HD) % NC));
      check("u_last", 32'(u_tlast), 32'(u_beat == ULEN - 1));
      if (u_beat == ULEN - 1) begin u_beat = 0; u_fcm++; end
      else u_beat++;
      u_total++;
    end
  end
  task automatic push(input int k, input bit add);
    Sample_Valid = 1;
    for (int c = 0; c < NC; c++) begin
      Sample_Data[c*DW +: DW] = val(k, c);
      if (add) q.push_back(val(k, c));
    end
    @(posedge clk); #1;
    Sample_Valid = 0;
  endtask
  task automatic upush(input int k);
    u_valid = 1;
    for (int c = 0; c < NC; c++) begin
      u_data[c*DW +: DW] = val(k, c);
      uq.push_back(val(k, c));
    end
    @(posedge clk); #1;
    u_valid = 0;
  endtask
  task automatic wait_beats(input int target, input int budget, input bit rnd);
    for (int i = 0; i < budget && total < target; i++) begin
      if (rnd) T_READY = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    check("beat_count", 32'(total), 32'(target));
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(T_VALID), 0);
    check("rst_send", 32'(Send_Frame), 0);
    check("rst_level", 32'(Fifo_Level), 0);
    check("rst_count", 32'(Frame_Count), 0);
    check("rst_flags", {30'd0, Overflow, Underrun}, 0);
    reset = 0;
    @(posedge clk); #1;
    Enable = 1; T_READY = 1;
    for (int k = 0; k < 16; k++) push(k, 1);
    check("lvl16", 32'(Fifo_Level), 16);
    check("idle_at_16", 32'(T_VALID), 0);
    @(posedge clk); #1;
    check("valid_rise", 32'(T_VALID), 1);
    check("send_rise", 32'(Send_Frame), 1);
    check("first_user", 32'(T_USER), 0);
    wait_beats(FLEN, 300, 0);
    check("fc1", 32'(Frame_Count), 1);
    check("send_done", 32'(Send_Frame), 0);
    check("lvl_empty", 32'(Fifo_Level), 0);
    check("no_underrun", 32'(Underrun), 0);
    T_READY = 0;
    for (int k = 16; k < 32; k++) push(k, 1);
    @(posedge clk); #1;
    check("valid_no_ready", 32'(T_VALID), 1);
    wait_beats(2*FLEN, 1000, 1);
    T_READY = 1;
    check("fc2", 32'(Frame_Count), 2);
    Enable = 0;
    for (int k = 32; k < 64; k++) push(k, 1);
    check("lvl_full", 32'(Fifo_Level), 32);
    check("ovf_before", 32'(Overflow), 0);
    push(64, 0);
    check("lvl_still_full", 32'(Fifo_Level), 32);
    check("ovf_set", 32'(Overflow), 1);
    Clear_Flags = 1;
    @(posedge clk); #1;
    Clear_Flags = 0;
    check("ovf_clear", 32'(Overflow), 0);
    Enable = 1;
    wait_beats(4*FLEN, 600, 0);
    check("fc4", 32'(Frame_Count), 4);
    check("drained", 32'(Fifo_Level), 0);
    check("set33_absent", 32'(q.size()), 0);
    check("no_underrun2", 32'(Underrun), 0);
    for (int k = 100; k < 116; k++) push(k, 1);
    wait_beats(4*FLEN + 20, 300, 0);
    reset = 1;
    #1;
    q.delete();
    check("mid_valid", 32'(T_VALID), 0);
    check("mid_data", T_DATA, 0);
    check("mid_user", 32'(T_USER), 0);
    check("mid_last", 32'(T_LAST), 0);
    check("mid_send", 32'(Send_Frame), 0);
    check("mid_level", 32'(Fifo_Level), 0);
    check("mid_count", 32'(Frame_Count), 0);
    @(posedge clk); #1;
    reset = 0;
    for (int k = 200; k < 216; k++) push(k, 1);
    wait_beats(5*FLEN + 20, 300, 0);
    check("fc_after_rst", 32'(Frame_Count), 1);
    u_enable = 1; u_ready = 1;
    for (int k = 0; k < 4; k++) upush(k);
    for (int i = 0; i < 40 && u_total < 16 + HD; i++) begin @(posedge clk); #1; end
    check("u_beats4", 32'(u_total), 32'(16 + HD));
    check("u_starved", 32'(u_tvalid), 0);
    @(posedge clk); #1;
    check("u_underrun", 32'(u_underrun), 1);
    check("u_in_frame", 32'(u_send), 1);
    check("u_still_low", 32'(u_tvalid), 0);
    upush(4);
    check("u_resume_valid", 32'(u_tvalid), 1);
    check("u_resume_user", 32'(u_tuser), 0);
    check("u_resume_data", u_tdata, val(4, 0));
    for (int k = 5; k < 8; k++) upush(k);
    for (int i = 0; i < 60 && u_total < ULEN; i++) begin @(posedge clk); #1; end
    check("u_beats8", 32'(u_total), 32'(ULEN));
    check("u_fc", 32'(u_fc), 1);
    check("u_done", 32'(u_send), 0);
    u_clear = 1;
    @(posedge clk); #1;
    u_clear = 0;
    check("u_underrun_clear", 32'(u_underrun), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
